sram_rw_port_ctrl: RTL and testbench

Initiator that owns the single RW0 port of a synchronous single-port SRAM macro, for example the 512x128 data-array macro with a 4-lane write mask. It zero-fills the array after reset, then serves a valid/ready request channel of reads and masked writes. It captures the macro's one-cycle-late read data into a small response buffer, so the consumer can apply backpressure without losing data.

---
 rtl/sram_port_pkg.sv | 23 ++
 rtl/sram_resp_fifo.sv | 63 ++++++
 rtl/sram_rw_port_ctrl.sv | 122 ++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_pkg
// Description : Shared types and constants for the SRAM RW0 port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_port_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int c_DEFAULT_DEPTH  = 512;
    localparam int c_DEFAULT_DATA_W = 128;
    localparam int c_DEFAULT_MASK_W = 4;

    localparam int c_RESP_DEPTH = 2;
    localparam int c_PTR_W      = (c_RESP_DEPTH > 1) ? $clog2(c_RESP_DEPTH) : 1;
    localparam int c_OCC_W      = $clog2(c_RESP_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/sram_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_resp_fifo
// Description : Small synchronous response FIFO; owns resp_valid/resp_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_resp_fifo
    import sram_port_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               pop,
    output logic [c_OCC_W-1:0] occ,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata
);

    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(c_RESP_DEPTH - 1);

    logic [DATA_W-1:0]  r_mem [c_RESP_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               w_pop;

    assign w_pop      = pop && (r_occ != '0);
    assign occ        = r_occ;
    assign resp_valid = (r_occ != '0);
    assign resp_rdata = resp_valid ? r_mem[r_rd_ptr] : '0;

    // Storage needs no reset: an entry is only visible once counted in r_occ.
    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (push && !w_pop) begin
                r_occ <= r_occ + c_OCC_W'(1);
            end else if (w_pop && !push) begin
                r_occ <= r_occ - c_OCC_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_rw_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_rw_port_ctrl
// Description : Owns the RW0 port of a single-port SRAM: zero-fill after
//               reset, then valid/ready reads and masked writes.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rw_port_ctrl
    import sram_port_pkg::*;
#(
    parameter int               DEPTH         = c_DEFAULT_DEPTH,
    parameter int               ADDR_W        = $clog2(DEPTH),
    parameter int               DATA_W        = c_DEFAULT_DATA_W,
    parameter int               MASK_W        = c_DEFAULT_MASK_W,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam state_e            c_RST_STATE = INIT_ON_RESET ? INIT : RUN;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  r_fill_cnt;
    logic [ADDR_W-1:0]  w_fill_cnt_nxt;
    logic               r_inflight;
    logic               w_accept;
    logic               w_pop;
    logic [c_OCC_W-1:0] w_occ;
    logic [2:0]         w_credit;

    assign init_done = (r_state == RUN);
    assign w_pop     = resp_valid && resp_ready;

    // Entries the buffer will hold after this edge if nothing new is issued.
    assign w_credit  = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign req_ready = reset && (r_state == RUN) && (w_credit < 3'(c_RESP_DEPTH));
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= c_RST_STATE;
            r_fill_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
            r_inflight <= w_accept && !req_write;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        RW0_en         = 1'b0;
        RW0_wmode      = 1'b0;
        RW0_wmask      = '0;
        RW0_addr       = '0;
        RW0_wdata      = '0;
        if (reset) begin
            case (r_state)
                INIT: begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b1;
                    RW0_wmask = '1;
                    RW0_addr  = r_fill_cnt;
                    RW0_wdata = INIT_VALUE;
                    // Counter parks on the last address so it never wraps in INIT.
                    if (r_fill_cnt == c_LAST_ADDR) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_fill_cnt_nxt = r_fill_cnt + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        RW0_en    = 1'b1;
                        RW0_wmode = req_write;
                        RW0_wmask = req_write ? req_wmask : '0;
                        RW0_addr  = req_addr;
                        RW0_wdata = req_wdata;
                    end
                end
                default: w_state_nxt = c_RST_STATE;
            endcase
        end
    end

    sram_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (r_inflight),
        .push_data  (RW0_rdata),
        .pop        (resp_ready),
        .occ        (w_occ),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_rw_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_rw_port_ctrl
// Description : Directed self-checking bench with a behavioural 512x128 macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_rw_port_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [8:0]   req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_wmask;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_rdata;
    logic         init_done;
    logic [8:0]   RW0_addr;
    logic         RW0_en;
    logic         RW0_wmode;
    logic [3:0]   RW0_wmask;
    logic [127:0] RW0_wdata;
    logic [127:0] RW0_rdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic seed;
    logic [127:0] mem [512];

    always #5 clock = ~clock;

    sram_rw_port_ctrl u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .RW0_addr   (RW0_addr),
        .RW0_en     (RW0_en),
        .RW0_wmode  (RW0_wmode),
        .RW0_wmask  (RW0_wmask),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (RW0_rdata)
    );

    // Macro model: junk-seeded array, masked 32-bit lanes, registered read.
    always @(posedge clock) begin
        if (seed) begin
            for (int i = 0; i < 512; i++) mem[i] <= {4{32'hDEAD0000 | 32'(i)}};
            RW0_rdata <= {4{32'hBAD0BAD0}};
        end else if (RW0_en) begin
            if (RW0_wmode) begin
                for (int l = 0; l < 4; l++)
                    if (RW0_wmask[l]) mem[RW0_addr][l*32 +: 32] <= RW0_wdata[l*32 +: 32];
            end else begin
                RW0_rdata <= mem[RW0_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] pat(input logic [8:0] a);
        return {4{24'hA5C3E1, a[7:0]}};
    endfunction

    // Walks DEPTH fill cycles expecting only fill writes, then init_done.
    task automatic fill_check(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_addr === 9'(i) &&
                  RW0_wmask === 4'hF && RW0_wdata === 128'd0 && req_ready === 1'b0 &&
                  init_done === 1'b0 && resp_valid === 1'b0))
                errs++;
            tick();
        end
        chk({tag, "_traffic_errs"}, 128'(errs), 128'd0);
        chk({tag, "_init_done"}, 128'(init_done), 128'd1);
    endtask

    initial begin
        int idx;
        int got;
        int errs;

        reset      = 1'b0;
        seed       = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = 1'b1;
        tick();
        seed = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_init_done", 128'(init_done), 128'd0);
        chk("rst_rw0_en", 128'(RW0_en), 128'd0);
        chk("rst_resp_rdata", resp_rdata, 128'd0);

        // Fill with a read held pending (INIT gating), then read 0x1FF
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h1FF;
        #1;
        fill_check("fill1");
        chk("rd1ff_ready", 128'(req_ready), 128'd1);
        chk("rd1ff_en", 128'(RW0_en), 128'd1);
        chk("rd1ff_wmode", 128'(RW0_wmode), 128'd0);
        chk("rd1ff_addr", 128'(RW0_addr), 128'h1FF);
        tick();
        req_valid = 1'b0;
        #1;
        chk("rd1ff_lat1_valid", 128'(resp_valid), 128'd0);
        tick();
        chk("rd1ff_valid", 128'(resp_valid), 128'd1);
        chk("rd1ff_data", resp_rdata, 128'd0);
        tick();

        // Masked write then read on the next cycle
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h005;
        req_wdata = '1;
        req_wmask = 4'b0101;
        #1;
        chk("mw_ready", 128'(req_ready), 128'd1);
        chk("mw_wmask", 128'(RW0_wmask), 128'h5);
        chk("mw_wmode", 128'(RW0_wmode), 128'd1);
        tick();
        req_write = 1'b0;
        #1;
        chk("mw_rd_en", 128'(RW0_en), 128'd1);
        chk("mw_rd_wmode", 128'(RW0_wmode), 128'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("mw_lat1_valid", 128'(resp_valid), 128'd0);
        tick();
        chk("mw_valid", 128'(resp_valid), 128'd1);
        chk("mw_data", resp_rdata, 128'h00000000_FFFFFFFF_00000000_FFFFFFFF);
        tick();

        // Seed 0x10..0x1F with distinct patterns
        errs = 0;
        for (int a = 16; a < 32; a++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 9'(a);
            req_wdata = pat(9'(a));
            req_wmask = 4'hF;
            #1;
            if (req_ready !== 1'b1) errs++;
            tick();
        end
        chk("seed_wr_stalls", 128'(errs), 128'd0);

        // Streaming reads with resp_ready=1
        errs = 0;
        for (int k = 0; k < 18; k++) begin
            req_valid = (k < 16);
            req_write = 1'b0;
            req_addr  = 9'(16 + k);
            #1;
            if (k < 16 && req_ready !== 1'b1) errs++;
            if (k >= 2) begin
                chk($sformatf("stream_valid_%0d", k - 2), 128'(resp_valid), 128'd1);
                chk($sformatf("stream_data_%0d", k - 2), resp_rdata, pat(9'(16 + k - 2)));
            end
            tick();
        end
        chk("stream_stalls", 128'(errs), 128'd0);
        chk("stream_drained", 128'(resp_valid), 128'd0);

        // Backpressure: four reads with resp_ready held low
        resp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = 9'(16 + idx);
            #1;
            if (req_ready) idx++;
            if (c == 5) begin
                chk("bp_accepted", 128'(idx), 128'd2);
                chk("bp_ready", 128'(req_ready), 128'd0);
                chk("bp_hold_valid", 128'(resp_valid), 128'd1);
                chk("bp_hold_data", resp_rdata, pat(9'h010));
            end
            tick();
        end
        resp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            req_valid = (idx < 4);
            req_addr  = 9'(16 + idx);
            #1;
            if (resp_valid) begin
                chk($sformatf("bp_data_%0d", got), resp_rdata, pat(9'(16 + got)));
                got++;
            end
            if (req_valid && req_ready) idx++;
            tick();
        end
        chk("bp_resp_count", 128'(got), 128'd4);
        chk("bp_req_count", 128'(idx), 128'd4);
        req_valid = 1'b0;
        tick();
        tick();
        chk("bp_idle_valid", 128'(resp_valid), 128'd0);

        // Reset the cycle after a read is accepted
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h010;
        #1;
        chk("mr_acc_ready", 128'(req_ready), 128'd1);
        tick();
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        tick();
        chk("mr_rst_en", 128'(RW0_en), 128'd0);
        chk("mr_rst_valid", 128'(resp_valid), 128'd0);
        chk("mr_rst_ready", 128'(req_ready), 128'd0);
        chk("mr_rst_init_done", 128'(init_done), 128'd0);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 9'h010;
        #1;
        chk("mr_fill_addr0", 128'(RW0_addr), 128'd0);
        fill_check("fill2");
        chk("mr_rd_ready", 128'(req_ready), 128'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("mr_rd_lat1_valid", 128'(resp_valid), 128'd0);
        tick();
        chk("mr_rd_valid", 128'(resp_valid), 128'd1);
        chk("mr_rd_data", resp_rdata, 128'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
